// File: rtl/audio_crossfade.sv
// Source selector that crossfades linearly, one step per CODEC sample strobe, when sel changes.
// Optional build macro FADE_THROUGH_ZERO_EN: fade out to silence over M samples, then fade in over M samples.
//
// state      | meaning
// S_IDLE     | passing src[cur_sel] through unscaled
// S_FADE     | linear crossfade cur_sel -> tgt_sel (single-phase build)
// S_FADE_OUT | ramping src[cur_sel] down to zero (through-zero build)
// S_FADE_IN  | ramping src[tgt_sel] up from zero (through-zero build)
module audio_crossfade #(
    parameter int WIDTH     = 24,
    parameter int NSRC      = 4,
    parameter int FADE_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [1:0]               sel,
    input  logic [NSRC*WIDTH-1:0]    src_left,
    input  logic [NSRC*WIDTH-1:0]    src_right,
    output logic signed [WIDTH-1:0]  out_left,
    output logic signed [WIDTH-1:0]  out_right,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int PW = WIDTH + FADE_LOG2 + 2;
    localparam int M  = 1 << FADE_LOG2;
    localparam logic [FADE_LOG2-1:0] CNT_LAST = FADE_LOG2'(M - 1);

`ifdef FADE_THROUGH_ZERO_EN
    typedef enum logic [1:0] {S_IDLE, S_FADE_OUT, S_FADE_IN} state_t;
    localparam state_t S_START = S_FADE_OUT;
`else
    typedef enum logic {S_IDLE, S_FADE} state_t;
    localparam state_t S_START = S_FADE;
`endif

    state_t                  r_state;
    logic [1:0]              r_cur;
    logic [1:0]              r_tgt;
    logic [FADE_LOG2-1:0]    r_cnt;
    logic signed [WIDTH-1:0] r_left;
    logic signed [WIDTH-1:0] r_right;
    logic                    r_valid;
    logic                    r_busy;

    logic [1:0]              w_sel_eff;
    logic [FADE_LOG2:0]      w_wa;
    logic [FADE_LOG2:0]      w_wb;
    logic signed [WIDTH-1:0] w_a_l, w_a_r, w_b_l, w_b_r;
    logic signed [WIDTH-1:0] w_mix_l, w_mix_r;

    function automatic logic signed [WIDTH-1:0] pick(
        input logic [NSRC*WIDTH-1:0] v,
        input logic [1:0]            idx
    );
        return v[idx*WIDTH +: WIDTH];
    endfunction

    // Weights sum to at most M, so the sum stays inside PW bits and needs no saturation.
    function automatic logic signed [WIDTH-1:0] mix(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic [FADE_LOG2:0]      wa,
        input logic [FADE_LOG2:0]      wb
    );
        logic signed [PW-1:0] pa;
        logic signed [PW-1:0] pb;
        pa = PW'(a) * $signed({{(PW-FADE_LOG2-1){1'b0}}, wa});
        pb = PW'(b) * $signed({{(PW-FADE_LOG2-1){1'b0}}, wb});
        return WIDTH'((pa + pb) >>> FADE_LOG2);
    endfunction

    assign w_sel_eff = (int'(sel) < NSRC) ? sel : 2'd0;

    assign w_a_l = pick(src_left,  r_cur);
    assign w_a_r = pick(src_right, r_cur);
    assign w_b_l = pick(src_left,  r_tgt);
    assign w_b_r = pick(src_right, r_tgt);

    always_comb begin
        w_wa = (FADE_LOG2+1)'(M) - {1'b0, r_cnt};
        w_wb = {1'b0, r_cnt};
`ifdef FADE_THROUGH_ZERO_EN
        if (r_state == S_FADE_IN) w_wa = '0;
        else                      w_wb = '0;
`endif
    end

    assign w_mix_l = mix(w_a_l, w_b_l, w_wa, w_wb);
    assign w_mix_r = mix(w_a_r, w_b_r, w_wa, w_wb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cur   <= 2'd0;
            r_tgt   <= 2'd0;
            r_cnt   <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        // First fade step has weight M on the current source, i.e. src[cur] unscaled.
                        r_left  <= w_a_l;
                        r_right <= w_a_r;
                        if (w_sel_eff == r_cur) begin
                            r_busy <= 1'b0;
                        end else begin
                            r_tgt   <= w_sel_eff;
                            r_cnt   <= FADE_LOG2'(1);
                            r_busy  <= 1'b1;
                            r_state <= S_START;
                        end
                    end
`ifdef FADE_THROUGH_ZERO_EN
                    S_FADE_OUT: begin
                        r_left  <= w_mix_l;
                        r_right <= w_mix_r;
                        r_busy  <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_FADE_IN;
                        end
                    end
                    S_FADE_IN: begin
                        r_left  <= w_mix_l;
                        r_right <= w_mix_r;
                        r_busy  <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_cur   <= r_tgt;
                            r_state <= S_IDLE;
                        end
                    end
`else
                    S_FADE: begin
                        r_left  <= w_mix_l;
                        r_right <= w_mix_r;
                        r_busy  <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_cur   <= r_tgt;
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_left  = r_left;
    assign out_right = r_right;
    assign out_valid = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_audio_crossfade.sv
// Bench for audio_crossfade: directed spec scenarios plus randomized traffic against a floor-division reference model.
module tb_audio_crossfade;

    localparam int W  = 24;
    localparam int NS = 3;
    localparam int FL = 2;
    localparam int M  = 4;
`ifdef FADE_THROUGH_ZERO_EN
    localparam int L = 2 * M;
`else
    localparam int L = M;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [1:0]           sel;
    logic [NS*W-1:0]      src_left;
    logic [NS*W-1:0]      src_right;
    logic signed [W-1:0]  out_left;
    logic signed [W-1:0]  out_right;
    logic                 out_valid;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int sl[NS];
    int sr[NS];

    // reference model: fade position m_pos (-1 = not fading), step index within the fade
    int     m_cur, m_tgt, m_pos;
    longint m_l, m_r;
    logic   m_busy;

    audio_crossfade #(.WIDTH(W), .NSRC(NS), .FADE_LOG2(FL)) dut (
        .clk(clk), .reset(reset), .en(en), .sel(sel),
        .src_left(src_left), .src_right(src_right),
        .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint n);
        longint q;
        q = n / M;
        if ((n % M) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint fval(input longint a, input longint b, input int p);
`ifdef FADE_THROUGH_ZERO_EN
        if (p < M) return fdiv(a * (M - p));
        return fdiv(b * (p - M));
`else
        return fdiv(a * (M - p) + b * p);
`endif
    endfunction

    task automatic pack();
        for (int i = 0; i < NS; i++) begin
            src_left[i*W +: W]  = W'(sl[i]);
            src_right[i*W +: W] = W'(sr[i]);
        end
    endtask

    task automatic rand_src();
        for (int i = 0; i < NS; i++) begin
            sl[i] = int'($urandom) >>> 8;
            sr[i] = int'($urandom) >>> 8;
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_pos = -1;
        m_l = 0; m_r = 0; m_busy = 1'b0;
    endtask

    task automatic model_step();
        int s;
        s = (int'(sel) >= NS) ? 0 : int'(sel);
        if (m_pos < 0) begin
            if (s == m_cur) begin
                m_l = sl[m_cur]; m_r = sr[m_cur]; m_busy = 1'b0;
            end else begin
                m_tgt = s; m_pos = 0;
            end
        end
        if (m_pos >= 0) begin
            m_l = fval(sl[m_cur], sl[m_tgt], m_pos);
            m_r = fval(sr[m_cur], sr[m_tgt], m_pos);
            m_busy = 1'b1;
            m_pos++;
            if (m_pos == L) begin
                m_cur = m_tgt; m_pos = -1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_left"},  out_left,  m_l);
        chk({tag, "_right"}, out_right, m_r);
        chk({tag, "_busy"},  busy,      m_busy);
    endtask

    task automatic en_pulse();
        @(negedge clk);
        pack();
        en = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        check_model("step");
        chk("valid_hi", out_valid, 1);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("valid_lo", out_valid, 0);
    endtask

    task automatic burst(input int n);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_src();
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
            pack();
            @(posedge clk);
            model_step();
            #1;
            check_model("burst");
            chk("burst_valid", out_valid, 1);
            @(negedge clk);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("burst_valid_lo", out_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_model("reset");
        chk("reset_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int exp_seq[9];
        reset = 1'b1;
        en    = 1'b0;
        sel   = 2'd0;
        for (int i = 0; i < NS; i++) begin sl[i] = 0; sr[i] = 0; end
        pack();
        model_reset();
        #1;
        check_model("por");
        chk("por_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        // basic fade 0 -> 1
`ifdef FADE_THROUGH_ZERO_EN
        sl[0] = 800; sr[0] = 800; sl[1] = 400; sr[1] = 400; sl[2] = 0; sr[2] = 0;
        exp_seq = '{800, 600, 400, 200, 0, 100, 200, 300, 400};
`else
        sl[0] = 1000; sr[0] = 1000; sl[1] = -1000; sr[1] = -1000; sl[2] = 0; sr[2] = 0;
        exp_seq = '{1000, 500, 0, -500, -1000, 0, 0, 0, 0};
`endif
        en_pulse();
        sel = 2'd1;
        for (int i = 0; i <= L; i++) begin
            en_pulse();
            chk("basic_left", out_left, exp_seq[i]);
            chk("basic_right", out_right, exp_seq[i]);
            chk("basic_busy", busy, (i < L) ? 1 : 0);
        end

        // floor rounding
        do_reset();
        sl[0] = 1; sr[0] = 1; sl[1] = 0; sr[1] = 0;
        sel = 2'd1;
        exp_seq = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i <= L; i++) begin
            en_pulse();
`ifndef FADE_THROUGH_ZERO_EN
            chk("round_pos", out_left, exp_seq[i]);
`endif
        end
        do_reset();
        sl[0] = -1; sr[0] = -1;
        exp_seq = '{-1, -1, -1, -1, 0, 0, 0, 0, 0};
        for (int i = 0; i <= L; i++) begin
            en_pulse();
`ifndef FADE_THROUGH_ZERO_EN
            chk("round_neg", out_left, exp_seq[i]);
`endif
        end

        // sel change mid-fade is ignored until the fade completes
        do_reset();
        sl[0] = 100; sr[0] = -100; sl[1] = 200; sr[1] = -200; sl[2] = 300; sr[2] = -300;
        sel = 2'd1;
        en_pulse();
        en_pulse();
        sel = 2'd2;
        for (int i = 2; i < L; i++) en_pulse();
        en_pulse();
        chk("toggle_first_left", out_left, 200);
        chk("toggle_first_right", out_right, -200);
        chk("toggle_busy", busy, 1);
        for (int i = 1; i <= L; i++) en_pulse();

        // no strobes: nothing moves
        sel = 2'd0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("idle_left", out_left, m_l);
            chk("idle_busy", busy, m_busy);
            chk("idle_valid", out_valid, 0);
        end
        en_pulse();

        // sel beyond NSRC maps to source 0
        sel = 2'd3;
        for (int i = 0; i <= L + 1; i++) en_pulse();

        // mid-fade reset followed by a fresh start
        sel = 2'd1;
        en_pulse();
        en_pulse();
        do_reset();
        en_pulse();

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_reset();
            end else if (r < 5) begin
                burst(int'($urandom_range(2, 6)));
            end else begin
                rand_src();
                if ($urandom_range(0, 2) == 0) sel = 2'($urandom_range(0, 3));
                en_pulse();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
